// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: accepts a framed word stream
// (header, N words, XOR checksum), writes it out, reads it back, then releases the CPU.
module imem_boot_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter int          BASE_ADDR = 0,
  parameter logic [15:0] MAGIC     = 16'hB007
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD, S_CSUM, S_VERIFY, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t              state;
  logic [ADDR_W:0]     n_words;
  logic [ADDR_W:0]     idx;
  logic [ADDR_W:0]     words_cnt;
  logic [DATA_W-1:0]   xor_acc;
  logic [DATA_W-1:0]   vxor;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_q;
  logic [1:0]          err_q;

  logic [ADDR_W:0]     hdr_n;
  logic [ADDR_W:0]     idx_nxt;
  logic [ADDR_W-1:0]   idx_addr;
  logic [DATA_W-1:0]   vxor_nxt;

  assign hdr_n    = in_data[ADDR_W:0];
  assign idx_nxt  = idx + ONE;
  assign idx_addr = BASE + idx[ADDR_W-1:0];
  assign vxor_nxt = vxor ^ mem_rdata;

  // Status outputs are single-level decodes of the state register.
  assign in_ready     = (state == S_HDR) || (state == S_LOAD) || (state == S_CSUM);
  assign busy         = in_ready || (state == S_VERIFY);
  assign done         = (state == S_DONE);
  assign error        = (state == S_ERR);
  assign cpu_hold     = (state != S_DONE);
  assign mem_read     = (state == S_VERIFY);
  assign mem_write    = wr_q;
  assign mem_addr     = 32'(addr_q);
  assign mem_wdata    = wdata_q;
  assign err_code     = err_q;
  assign words_loaded = words_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n_words   <= '0;
      idx       <= '0;
      words_cnt <= '0;
      xor_acc   <= '0;
      vxor      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      wr_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_HDR;
            words_cnt <= '0;
          end
        end
        S_ERR: begin
          if (start) begin
            state     <= S_HDR;
            err_q     <= 2'b00;
            words_cnt <= '0;
          end
        end
        S_HDR: begin
          if (in_valid) begin
            if (in_data[31:16] != MAGIC) begin
              state <= S_ERR;
              err_q <= 2'b01;
            end else if (hdr_n == '0 || hdr_n > DEPTH) begin
              state <= S_ERR;
              err_q <= 2'b10;
            end else begin
              n_words <= hdr_n;
              idx     <= '0;
              xor_acc <= '0;
              state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Write is registered: it appears on the port the cycle after the accept.
          if (in_valid) begin
            wr_q      <= 1'b1;
            addr_q    <= idx_addr;
            wdata_q   <= in_data;
            xor_acc   <= xor_acc ^ in_data;
            idx       <= idx_nxt;
            words_cnt <= words_cnt + ONE;
            if (idx_nxt == n_words)
              state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (in_valid) begin
            if (in_data != xor_acc) begin
              state <= S_ERR;
              err_q <= 2'b11;
            end else begin
              idx    <= '0;
              vxor   <= '0;
              addr_q <= BASE;
              state  <= S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          // Read data is combinational, so each cycle folds in the word at addr_q.
          vxor   <= vxor_nxt;
          idx    <= idx_nxt;
          addr_q <= BASE + idx_nxt[ADDR_W-1:0];
          if (idx_nxt == n_words) begin
            if (vxor_nxt != xor_acc) begin
              state <= S_ERR;
              err_q <= 2'b11;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (base 0 and base 1022) share one stream;
// a queue-based reference model predicts writes, readback count and final status.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, fault_a;
  logic [31:0] in_data;

  logic        in_ready_a, mem_write_a, mem_read_a, busy_a, done_a, error_a, cpu_hold_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [1:0]  err_code_a;
  logic [10:0] words_loaded_a;
  logic        in_ready_b, mem_write_b, mem_read_b, busy_b, done_b, error_b, cpu_hold_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [1:0]  err_code_b;
  logic [10:0] words_loaded_b;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(0), .MAGIC(16'hB007)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .mem_write(mem_write_a), .mem_read(mem_read_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .busy(busy_a), .done(done_a), .error(error_a), .err_code(err_code_a),
    .cpu_hold(cpu_hold_a), .words_loaded(words_loaded_a));

  imem_boot_loader #(.ADDR_W(10), .DATA_W(32), .BASE_ADDR(1022), .MAGIC(16'hB007)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .mem_write(mem_write_b), .mem_read(mem_read_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b), .done(done_b), .error(error_b), .err_code(err_code_b),
    .cpu_hold(cpu_hold_b), .words_loaded(words_loaded_b));

  // Memory models; instance a can be made to return a corrupt word at addr 1 on reads.
  always @(posedge clk) begin
    if (mem_write_a) mem_a[mem_addr_a[9:0]] <= mem_wdata_a;
    if (mem_write_b) mem_b[mem_addr_b[9:0]] <= mem_wdata_b;
  end
  assign mem_rdata_a = (fault_a && mem_read_a && mem_addr_a == 32'd1) ? 32'hDEADBEEF
                                                                       : mem_a[mem_addr_a[9:0]];
  assign mem_rdata_b = mem_b[mem_addr_b[9:0]];

  // Port monitor: every write as {addr, data}, read-cycle counts, read/write overlap.
  logic [41:0] wq_a[$], wq_b[$];
  int rd_a = 0, rd_b = 0, ovl = 0;
  always @(negedge clk) begin
    if (mem_write_a) wq_a.push_back({mem_addr_a[9:0], mem_wdata_a});
    if (mem_write_b) wq_b.push_back({mem_addr_b[9:0], mem_wdata_b});
    if (mem_read_a) rd_a <= rd_a + 1;
    if (mem_read_b) rd_b <= rd_b + 1;
    if ((mem_read_a && mem_write_a) || (mem_read_b && mem_write_b)) ovl <= ovl + 1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected writes per instance, error code, word count, readback cycles.
  logic [41:0] ew_a[$], ew_b[$];
  task automatic model(input logic [31:0] s[$], input int base, input bit flt, input int inst,
                       output int err, output int wl, output int nrd);
    logic [31:0] x, vx, rb;
    logic [41:0] e;
    int n, a;
    err = 0; wl = 0; nrd = 0;
    if (inst == 0) ew_a.delete(); else ew_b.delete();
    if (s[0][31:16] != 16'hB007) begin err = 1; return; end
    n = int'(s[0][10:0]);
    if (n == 0 || n > 1024) begin err = 2; return; end
    x = 0;
    for (int i = 0; i < n; i++) begin
      a = (base + i) % 1024;
      e = {a[9:0], s[1+i]};
      if (inst == 0) ew_a.push_back(e); else ew_b.push_back(e);
      x ^= s[1+i];
    end
    wl = n;
    if (s[n+1] != x) begin err = 3; return; end
    nrd = n;
    vx = 0;
    for (int i = 0; i < n; i++) begin
      rb = (flt && (base + i) % 1024 == 1) ? 32'hDEADBEEF : s[1+i];
      vx ^= rb;
    end
    if (vx != x) err = 3;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int guard = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      start    = 1'($urandom_range(1));
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b1; in_data = w;
    while (!in_ready_a && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic cmp_writes(input string nm, input int inst, input int ws);
    int bad = 0, got;
    if (inst == 0) begin
      got = wq_a.size() - ws;
      chk({nm, "_nwr_a"}, got, ew_a.size());
      for (int i = 0; i < ew_a.size() && i < got; i++) if (wq_a[ws+i] != ew_a[i]) bad++;
      chk({nm, "_wr_a"}, bad, 0);
    end else begin
      got = wq_b.size() - ws;
      chk({nm, "_nwr_b"}, got, ew_b.size());
      for (int i = 0; i < ew_b.size() && i < got; i++) if (wq_b[ws+i] != ew_b[i]) bad++;
      chk({nm, "_wr_b"}, bad, 0);
    end
  endtask

  // terr/twl >= 0 are hand-derived expectations for instance a; -1 defers to the model.
  task automatic run_stream(input string nm, input logic [31:0] s[$], input bit f,
                            input int gap, input int terr, input int twl);
    int ea, wa, ra, eb, wb, rb, nsend, ws_a, ws_b, r0a, r0b, k;
    model(s, 0, f, 0, ea, wa, ra);
    model(s, 1022, 1'b0, 1, eb, wb, rb);
    if (terr >= 0) ea = terr;
    if (twl >= 0) wa = twl;
    fault_a = f;
    ws_a = wq_a.size(); ws_b = wq_b.size(); r0a = rd_a; r0b = rd_b;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({nm, "_busy_hdr"}, busy_a, 1);
    chk({nm, "_hold_hdr"}, cpu_hold_a, 1);
    nsend = (ea == 1 || ea == 2) ? 1 : s.size();
    for (int i = 0; i < nsend; i++) send_word(s[i], gap);
    if (ea == 1 || ea == 2) chk({nm, "_hdr_err_next"}, error_a, 1);
    k = 0;
    while (!((done_a || error_a) && (done_b || error_b)) && k < 3000) begin
      if (done_a || error_a || done_b || error_b) start = 1'b0;
      else start = 1'($urandom_range(1));
      in_valid = 1'($urandom_range(1));
      in_data  = $urandom;
      @(negedge clk);
      k++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (k >= 3000) chk({nm, "_end_timeout"}, 0, 1);
    @(negedge clk);
    chk({nm, "_err_a"}, err_code_a, ea);
    chk({nm, "_done_a"}, done_a, ea == 0);
    chk({nm, "_error_a"}, error_a, ea != 0);
    chk({nm, "_hold_a"}, cpu_hold_a, ea != 0);
    chk({nm, "_wl_a"}, words_loaded_a, wa);
    chk({nm, "_rd_a"}, rd_a - r0a, ra);
    cmp_writes(nm, 0, ws_a);
    chk({nm, "_err_b"}, err_code_b, eb);
    chk({nm, "_done_b"}, done_b, eb == 0);
    chk({nm, "_wl_b"}, words_loaded_b, wb);
    chk({nm, "_rd_b"}, rd_b - r0b, rb);
    cmp_writes(nm, 1, ws_b);
    fault_a = 1'b0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_busy"}, busy_a, 0);
    chk({nm, "_ready"}, in_ready_a, 0);
    chk({nm, "_done"}, done_a, 0);
    chk({nm, "_error"}, error_a, 0);
    chk({nm, "_errcode"}, err_code_a, 0);
    chk({nm, "_hold"}, cpu_hold_a, 1);
    chk({nm, "_wl"}, words_loaded_a, 0);
    chk({nm, "_wr_rd"}, {mem_write_a, mem_read_a}, 0);
    chk({nm, "_addr"}, mem_addr_a, 0);
    chk({nm, "_wdata"}, mem_wdata_a, 0);
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [31:0] w[6];
    bit          fault;
    int          gap;
    int          err;
    int          wl;
  } vec_t;
  vec_t tab[$];

  task automatic add_vec(input string nm, input int len, input logic [31:0] w0, w1, w2, w3, w4, w5,
                         input bit f, input int gap, input int err, input int wl);
    vec_t v;
    v.name = nm; v.len = len; v.fault = f; v.gap = gap; v.err = err; v.wl = wl;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    tab.push_back(v);
  endtask

  initial begin
    logic [31:0] s[$];
    logic [31:0] x, w;
    int n, kind;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; fault_a = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    reset = 1'b0;

    add_vec("normal",   5, 32'hB0070003, 32'h00A21002, 32'h00A21801, 32'h00E33801, 32'h00E33002, 0, 0, 0, 0, 3);
    add_vec("badmagic", 1, 32'hB0080003, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    add_vec("recover",  5, 32'hB0070003, 32'h00A21002, 32'h00A21801, 32'h00E33801, 32'h00E33002, 0, 0, 40, 0, 3);
    add_vec("n_zero",   1, 32'hB0070000, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    add_vec("n_1025",   1, 32'hB0070401, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    add_vec("badcsum",  5, 32'hB0070003, 32'h00A21002, 32'h00A21801, 32'h00E33801, 32'h00E33003, 0, 0, 0, 3, 3);
    add_vec("rdfault",  5, 32'hB0070003, 32'h00A21002, 32'h00A21801, 32'h00E33801, 32'h00E33002, 0, 1, 0, 3, 3);
    add_vec("wrap4",    6, 32'hB0070004, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h44444444, 0, 50, 0, 4);
    add_vec("n_one",    3, 32'hB0070001, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 1);

    foreach (tab[t]) begin
      s.delete();
      for (int i = 0; i < tab[t].len; i++) s.push_back(tab[t].w[i]);
      run_stream(tab[t].name, s, tab[t].fault, tab[t].gap, tab[t].err, tab[t].wl);
    end

    // Full-depth load: every location written once; instance b wraps past 1023.
    s.delete(); x = 0;
    s.push_back(32'hB0070400);
    for (int i = 0; i < 1024; i++) begin
      w = $urandom; s.push_back(w); x ^= w;
    end
    s.push_back(x);
    run_stream("full", s, 1'b0, 0, 0, 1024);

    // Reset in the middle of LOAD aborts to IDLE on the next cycle.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_word(32'hB0070005, 0);
    send_word(32'h0BADF00D, 0);
    send_word(32'h12345678, 0);
    chk("midrst_wl_before", words_loaded_a, 2);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    reset = 1'b0;
    s.delete();
    s.push_back(32'hB0070002); s.push_back(32'h0000FFFF); s.push_back(32'hFFFF0000); s.push_back(32'hFFFFFFFF);
    run_stream("after_rst", s, 1'b0, 20, 0, 2);

    // Randomized streams with backpressure, occasional bad frames and readback faults.
    for (int r = 0; r < 30; r++) begin
      s.delete(); x = 0;
      n = $urandom_range(1, 12);
      kind = $urandom_range(99);
      if (kind < 6)       s.push_back({16'hB00F, 5'd0, 11'(n)});
      else if (kind < 12) s.push_back({16'hB007, 5'd0, 11'($urandom_range(1, 2) == 1 ? 0 : 1025 + $urandom_range(1000))});
      else                s.push_back({16'hB007, 5'd0, 11'(n)});
      for (int i = 0; i < n; i++) begin
        w = $urandom; s.push_back(w); x ^= w;
      end
      if (kind >= 12 && kind < 22) x ^= 32'h1 << $urandom_range(31);
      s.push_back(x);
      run_stream($sformatf("rnd%0d", r), s, 1'($urandom_range(4) == 0), $urandom_range(60), -1, -1);
    end

    chk("rd_wr_overlap", ovl, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
